// File: rtl/br_redirect_ctl.sv
// br_redirect_ctl: keeps the oldest outstanding branch mispredict, pulses a backend flush
// and holds a valid/ready redirect toward fetch or the ucode sequencer.
module br_redirect_ctl #(
    parameter int PADDR_W = 64,
    parameter int ROBID_W = 6,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mispred_vld_ex0,
    input  logic [ROBID_W-1:0] mispred_robid_ex0,
    input  logic [PADDR_W-1:0] mispred_tgt_ex0,
    input  logic               mispred_ucbr_ex0,
    input  logic               rob_nuke,
    output logic               flush_vld,
    output logic [ROBID_W-1:0] flush_robid,
    output logic               redirect_vld,
    input  logic               redirect_rdy,
    output logic [PADDR_W-1:0] redirect_tgt,
    output logic               redirect_ucbr,
    output logic [CNT_W-1:0]   mispred_cnt
);
    typedef enum logic {IDLE, PEND} state_t;
    state_t state, state_nxt;
    logic older, accept, xfer;
    // flush_robid always holds the robid of the pending branch, so it doubles as the age reference
    always_comb begin
        older  = (mispred_robid_ex0[ROBID_W-1] == flush_robid[ROBID_W-1])
               ? (mispred_robid_ex0[ROBID_W-2:0] < flush_robid[ROBID_W-2:0])
               : (mispred_robid_ex0[ROBID_W-2:0] > flush_robid[ROBID_W-2:0]);
        accept = mispred_vld_ex0 & ~rob_nuke & ((state == IDLE) | older);
        xfer   = redirect_vld & redirect_rdy;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end
    always_comb begin
        state_nxt = rob_nuke ? IDLE : accept ? PEND : xfer ? IDLE : state;
    end
    always_comb begin
        redirect_vld = (state == PEND);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_vld     <= 1'b0;
            flush_robid   <= '0;
            redirect_tgt  <= '0;
            redirect_ucbr <= 1'b0;
            mispred_cnt   <= '0;
        end else begin
            flush_vld <= accept;
            if (accept) begin
                flush_robid   <= mispred_robid_ex0;
                redirect_tgt  <= mispred_tgt_ex0;
                redirect_ucbr <= mispred_ucbr_ex0;
                if (mispred_cnt != '1) mispred_cnt <= mispred_cnt + 1'b1;
            end
        end
    end
    a_redirect_stable: assert property (@(posedge clk) disable iff (reset)
        redirect_vld && !redirect_rdy && !accept |=> $stable(redirect_tgt) && $stable(redirect_ucbr));
    a_flush_single: assert property (@(posedge clk) disable iff (reset)
        flush_vld && !accept |=> !flush_vld);
endmodule
